// File: rtl/decode_exec_unit.sv
// decode_exec_unit: RV32I combinational decode, ID/EX pipeline register and EX-stage ALU.
// Optional MEM/WB operand forwarding is enabled by defining DECODE_EXEC_FWD_EN.
module decode_exec_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] id_instr,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_val,
    input  logic [31:0] id_rs2_val,
    input  logic        flush,
    input  logic        stall,
    input  logic        mem_reg_write,
    input  logic [4:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_val,
    input  logic [4:0]  wb_rd_addr,
    input  logic [31:0] wb_rd_val,
    output logic [4:0]  id_rs1_addr,
    output logic [4:0]  id_rs2_addr,
    output logic        id_jal,
    output logic [31:0] id_imm,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_result,
    output logic [31:0] ex_store_data,
    output logic [31:0] ex_branch_addr,
    output logic [4:0]  ex_rd_addr,
    output logic        ex_jal,
    output logic        ex_jalr,
    output logic        ex_branch,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_reg_write
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,  ALU_SUB = 4'd1,  ALU_SLL = 4'd2,  ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5,  ALU_SRL = 4'd6,  ALU_SRA = 4'd7,
        ALU_OR = 4'd8,   ALU_AND = 4'd9,  ALU_EQ = 4'd10,  ALU_NE = 4'd11,
        ALU_LT = 4'd12,  ALU_GE = 4'd13,  ALU_LTU = 4'd14, ALU_GEU = 4'd15
    } alu_op_e;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_imm;
    logic            w_jal, w_jalr, w_branch, w_mem_read, w_mem_write, w_reg_write;
    logic            w_alu_src, w_lui, w_auipc;
    alu_op_e         w_alu_op;

    logic [XLEN-1:0] r_pc, r_rs1_val, r_rs2_val, r_imm;
    logic [RW-1:0]   r_rs1_addr, r_rs2_addr, r_rd;
    logic            r_jal, r_jalr, r_branch, r_mem_read, r_mem_write, r_reg_write;
    logic            r_alu_src, r_lui, r_auipc;
    alu_op_e         r_alu_op;

    logic [XLEN-1:0] w_rs1_fwd, w_rs2_fwd, w_op1, w_op2, w_alu_res;
    logic            w_kill;

    assign w_opcode    = id_instr[6:0];
    assign w_funct3    = id_instr[14:12];
    assign id_rs1_addr = id_instr[19:15];
    assign id_rs2_addr = id_instr[24:20];

    assign w_imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign w_imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign w_imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
    assign w_imm_u = {id_instr[31:12], 12'b0};
    assign w_imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};

    // Map funct3 of OP / OP-IMM to an ALU operation; SUB only when allowed by the caller.
    function automatic alu_op_e arith_op(input logic [2:0] f3, input logic alt_sub, input logic alt_sra);
        case (f3)
            3'b000:  arith_op = alt_sub ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = alt_sra ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    endfunction

    // Instruction decode: control flags, ALU operation and immediate; unknown opcodes act as NOP.
    always_comb begin
        w_jal       = 1'b0;
        w_jalr      = 1'b0;
        w_branch    = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_reg_write = 1'b0;
        w_alu_src   = 1'b0;
        w_lui       = 1'b0;
        w_auipc     = 1'b0;
        w_alu_op    = ALU_ADD;
        w_imm       = '0;
        case (w_opcode)
            OPC_LUI:   begin w_lui = 1'b1; w_alu_src = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_u; end
            OPC_AUIPC: begin w_auipc = 1'b1; w_alu_src = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_u; end
            OPC_JAL:   begin w_jal = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_j; end
            OPC_JALR:  begin w_jalr = 1'b1; w_alu_src = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_i; end
            OPC_LOAD:  begin w_mem_read = 1'b1; w_alu_src = 1'b1; w_reg_write = 1'b1; w_imm = w_imm_i; end
            OPC_STORE: begin w_mem_write = 1'b1; w_alu_src = 1'b1; w_imm = w_imm_s; end
            OPC_OPIMM: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
                w_imm       = w_imm_i;
                w_alu_op    = arith_op(w_funct3, 1'b0, id_instr[30]);
            end
            OPC_OP: begin
                w_reg_write = 1'b1;
                w_alu_op    = arith_op(w_funct3, id_instr[30], id_instr[30]);
            end
            OPC_BRANCH: begin
                w_branch = 1'b1;
                w_imm    = w_imm_b;
                case (w_funct3)
                    3'b000:  w_alu_op = ALU_EQ;
                    3'b001:  w_alu_op = ALU_NE;
                    3'b100:  w_alu_op = ALU_LT;
                    3'b101:  w_alu_op = ALU_GE;
                    3'b110:  w_alu_op = ALU_LTU;
                    3'b111:  w_alu_op = ALU_GEU;
                    default: w_alu_op = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end

    assign id_jal = w_jal;
    assign id_imm = w_imm;
    assign w_kill = flush | stall;

    // ID/EX register: data always captured, controls squashed on flush/stall, everything cleared on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= '0; r_rs1_val <= '0; r_rs2_val <= '0; r_imm <= '0;
            r_rs1_addr <= '0; r_rs2_addr <= '0; r_rd <= '0;
            r_jal <= 1'b0; r_jalr <= 1'b0; r_branch <= 1'b0; r_mem_read <= 1'b0;
            r_mem_write <= 1'b0; r_reg_write <= 1'b0; r_alu_src <= 1'b0;
            r_lui <= 1'b0; r_auipc <= 1'b0; r_alu_op <= ALU_ADD;
        end else begin
            r_pc       <= id_pc;
            r_rs1_val  <= id_rs1_val;
            r_rs2_val  <= id_rs2_val;
            r_imm      <= w_imm;
            r_rs1_addr <= id_instr[19:15];
            r_rs2_addr <= id_instr[24:20];
            r_rd       <= id_instr[11:7];
            r_jal       <= w_jal       & ~w_kill;
            r_jalr      <= w_jalr      & ~w_kill;
            r_branch    <= w_branch    & ~w_kill;
            r_mem_read  <= w_mem_read  & ~w_kill;
            r_mem_write <= w_mem_write & ~w_kill;
            r_reg_write <= w_reg_write & ~w_kill;
            r_alu_src   <= w_alu_src   & ~w_kill;
            r_lui       <= w_lui       & ~w_kill;
            r_auipc     <= w_auipc     & ~w_kill;
            r_alu_op    <= w_kill ? ALU_ADD : w_alu_op;
        end
    end

`ifdef DECODE_EXEC_FWD_EN
    // Youngest producer wins: MEM result before WB result before register-file value.
    function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] addr, input logic [XLEN-1:0] reg_val);
        if (mem_reg_write && (mem_rd_addr == addr) && (addr != '0))
            fwd = mem_rd_val;
        else if ((wb_rd_addr == addr) && (addr != '0))
            fwd = wb_rd_val;
        else
            fwd = reg_val;
    endfunction

    assign w_rs1_fwd = fwd(r_rs1_addr, r_rs1_val);
    assign w_rs2_fwd = fwd(r_rs2_addr, r_rs2_val);
`else
    logic w_unused_fwd;
    assign w_rs1_fwd    = r_rs1_val;
    assign w_rs2_fwd    = r_rs2_val;
    assign w_unused_fwd = ^{mem_reg_write, mem_rd_addr, mem_rd_val, wb_rd_addr, wb_rd_val, r_rs1_addr, r_rs2_addr};
`endif

    assign w_op1 = r_lui ? '0 : (r_auipc ? r_pc : w_rs1_fwd);
    assign w_op2 = r_alu_src ? r_imm : w_rs2_fwd;

    // EX-stage ALU; comparisons return 0 or 1.
    always_comb begin
        w_alu_res = '0;
        case (r_alu_op)
            ALU_ADD:  w_alu_res = w_op1 + w_op2;
            ALU_SUB:  w_alu_res = w_op1 - w_op2;
            ALU_SLL:  w_alu_res = w_op1 << w_op2[4:0];
            ALU_SLT:  w_alu_res = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            ALU_SLTU: w_alu_res = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            ALU_XOR:  w_alu_res = w_op1 ^ w_op2;
            ALU_SRL:  w_alu_res = w_op1 >> w_op2[4:0];
            ALU_SRA:  w_alu_res = XLEN'($signed(w_op1) >>> w_op2[4:0]);
            ALU_OR:   w_alu_res = w_op1 | w_op2;
            ALU_AND:  w_alu_res = w_op1 & w_op2;
            ALU_EQ:   w_alu_res = {{(XLEN-1){1'b0}}, w_op1 == w_op2};
            ALU_NE:   w_alu_res = {{(XLEN-1){1'b0}}, w_op1 != w_op2};
            ALU_LT:   w_alu_res = {{(XLEN-1){1'b0}}, $signed(w_op1) < $signed(w_op2)};
            ALU_GE:   w_alu_res = {{(XLEN-1){1'b0}}, $signed(w_op1) >= $signed(w_op2)};
            ALU_LTU:  w_alu_res = {{(XLEN-1){1'b0}}, w_op1 < w_op2};
            ALU_GEU:  w_alu_res = {{(XLEN-1){1'b0}}, w_op1 >= w_op2};
            default:  w_alu_res = '0;
        endcase
    end

    assign ex_result      = w_alu_res;
    assign ex_store_data  = w_rs2_fwd;
    assign ex_branch_addr = r_jalr ? (w_alu_res & ~XLEN'(1)) : (r_pc + r_imm);
    assign ex_pc          = r_pc;
    assign ex_rd_addr     = r_rd;
    assign ex_jal         = r_jal;
    assign ex_jalr        = r_jalr;
    assign ex_branch      = r_branch;
    assign ex_mem_read    = r_mem_read;
    assign ex_mem_write   = r_mem_write;
    assign ex_reg_write   = r_reg_write;

endmodule

// File: tb/tb_decode_exec_unit.sv
// tb_decode_exec_unit: directed and random checks of decode_exec_unit against a behavioural model.
module tb_decode_exec_unit;

    logic        clock, reset;
    logic [31:0] id_instr, id_pc, id_rs1_val, id_rs2_val;
    logic        flush, stall, mem_reg_write;
    logic [4:0]  mem_rd_addr, wb_rd_addr;
    logic [31:0] mem_rd_val, wb_rd_val;
    logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
    logic        id_jal;
    logic [31:0] id_imm, ex_pc, ex_result, ex_store_data, ex_branch_addr;
    logic        ex_jal, ex_jalr, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write;

    int tests = 0;
    int fails = 0;

    decode_exec_unit dut (
        .clock(clock), .reset(reset), .id_instr(id_instr), .id_pc(id_pc),
        .id_rs1_val(id_rs1_val), .id_rs2_val(id_rs2_val), .flush(flush), .stall(stall),
        .mem_reg_write(mem_reg_write), .mem_rd_addr(mem_rd_addr), .mem_rd_val(mem_rd_val),
        .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val),
        .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_jal(id_jal), .id_imm(id_imm),
        .ex_pc(ex_pc), .ex_result(ex_result), .ex_store_data(ex_store_data),
        .ex_branch_addr(ex_branch_addr), .ex_rd_addr(ex_rd_addr), .ex_jal(ex_jal),
        .ex_jalr(ex_jalr), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] result, store, baddr;
        logic [4:0]  rd;
        logic [5:0]  flags; // jal, jalr, branch, mem_read, mem_write, reg_write
    } exp_t;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        logic [12:0] b;
        logic [20:0] j;
        logic [11:0] s;
        b = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        j = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        s = {ins[31:25], ins[11:7]};
        case (ins[6:0])
            7'h37, 7'h17:        return {ins[31:12], 12'h000};
            7'h6F:               return 32'($signed(j));
            7'h67, 7'h03, 7'h13: return 32'($signed(ins[31:20]));
            7'h23:               return 32'($signed(s));
            7'h63:               return 32'($signed(b));
            default:             return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] a, input logic [31:0] v,
                                            input logic mwe, input logic [4:0] ma, input logic [31:0] mv,
                                            input logic [4:0] wa, input logic [31:0] wv);
`ifdef DECODE_EXEC_FWD_EN
        if (a != 0 && mwe && ma == a) return mv;
        if (a != 0 && wa == a) return wv;
`endif
        return v;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic alt, input logic [31:0] x, input logic [31:0] y);
        int sh;
        sh = int'(y % 32);
        case (f3)
            3'd0: return alt ? x - y : x + y;
            3'd1: return x << sh;
            3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3: return (x < y) ? 32'd1 : 32'd0;
            3'd4: return x ^ y;
            3'd5: return alt ? 32'($signed(x) >>> sh) : x >> sh;
            3'd6: return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] v1,
                                   input logic [31:0] v2, input logic killed,
                                   input logic mwe, input logic [4:0] ma, input logic [31:0] mv,
                                   input logic [4:0] wa, input logic [31:0] wv);
        exp_t e;
        logic [31:0] a, b, imm;
        logic [2:0] f3;
        bit taken;
        f3  = ins[14:12];
        imm = ref_imm(ins);
        a   = ref_fwd(ins[19:15], v1, mwe, ma, mv, wa, wv);
        b   = ref_fwd(ins[24:20], v2, mwe, ma, mv, wa, wv);
        e.rd = ins[11:7];
        e.store = b;
        e.flags = 6'b0;
        e.result = a + b;
        if (!killed) begin
            case (ins[6:0])
                7'h37: begin e.result = imm;      e.flags = 6'b000001; end
                7'h17: begin e.result = pc + imm; e.flags = 6'b000001; end
                7'h6F: begin e.result = a + b;    e.flags = 6'b100001; end
                7'h67: begin e.result = a + imm;  e.flags = 6'b010001; end
                7'h03: begin e.result = a + imm;  e.flags = 6'b000101; end
                7'h23: begin e.result = a + imm;  e.flags = 6'b000010; end
                7'h13: begin e.result = ref_alu(f3, ins[30] && f3 == 3'd5, a, imm); e.flags = 6'b000001; end
                7'h33: begin e.result = ref_alu(f3, ins[30], a, b);                 e.flags = 6'b000001; end
                7'h63: begin
                    case (f3)
                        3'd0: taken = (a == b);
                        3'd1: taken = (a != b);
                        3'd4: taken = ($signed(a) < $signed(b));
                        3'd5: taken = ($signed(a) >= $signed(b));
                        3'd6: taken = (a < b);
                        default: taken = (a >= b);
                    endcase
                    e.result = taken ? 32'd1 : 32'd0;
                    e.flags = 6'b001000;
                end
                default: ;
            endcase
        end
        e.baddr = e.flags[4] ? (e.result & 32'hFFFF_FFFE) : pc + imm;
        return e;
    endfunction

    // Drive one instruction into ID, check decode, clock it into EX and check EX outputs.
    task automatic run(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] v1, input logic [31:0] v2,
                       input logic fl, input logic st, input logic mwe, input logic [4:0] ma,
                       input logic [31:0] mv, input logic [4:0] wa, input logic [31:0] wv);
        exp_t e;
        id_instr = ins; id_pc = pc; id_rs1_val = v1; id_rs2_val = v2; flush = fl; stall = st;
        #1;
        chk("id_rs1_addr", 32'(id_rs1_addr), 32'(ins[19:15]));
        chk("id_rs2_addr", 32'(id_rs2_addr), 32'(ins[24:20]));
        chk("id_imm", id_imm, ref_imm(ins));
        chk("id_jal", 32'(id_jal), (ins[6:0] == 7'h6F) ? 32'd1 : 32'd0);
        @(posedge clock); #1;
        flush = 1'b0; stall = 1'b0;
        mem_reg_write = mwe; mem_rd_addr = ma; mem_rd_val = mv; wb_rd_addr = wa; wb_rd_val = wv;
        #1;
        e = model(ins, pc, v1, v2, fl | st, mwe, ma, mv, wa, wv);
        chk("ex_result", ex_result, e.result);
        chk("ex_store_data", ex_store_data, e.store);
        chk("ex_branch_addr", ex_branch_addr, e.baddr);
        chk("ex_pc", ex_pc, pc);
        chk("ex_rd_addr", 32'(ex_rd_addr), 32'(e.rd));
        chk("ex_flags", 32'({ex_jal, ex_jalr, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write}), 32'(e.flags));
    endtask

    logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};

    initial begin
        logic [31:0] ins;
        reset = 1'b1; flush = 1'b0; stall = 1'b0;
        id_instr = 32'h0050_0293; id_pc = 32'h44; id_rs1_val = 32'h11; id_rs2_val = 32'h22;
        mem_reg_write = 1'b0; mem_rd_addr = 5'd0; mem_rd_val = 32'h0; wb_rd_addr = 5'd0; wb_rd_val = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_result", ex_result, 32'h0);
        chk("rst_pc", ex_pc, 32'h0);
        chk("rst_baddr", ex_branch_addr, 32'h0);
        chk("rst_flags", 32'({ex_jal, ex_jalr, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write}), 32'h0);
        reset = 1'b0;

        // addi x5,x0,5
        run(32'h0050_0293, 32'h0, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("addi_result", ex_result, 32'd5);
        chk("addi_rd", 32'(ex_rd_addr), 32'd5);
        chk("addi_rw", 32'(ex_reg_write), 32'd1);

        // add x1,x5,x0 with MEM and WB both targeting x5
        run(32'h0002_80B3, 32'h4, 32'h0, 32'h0, 0, 0, 1, 5'd5, 32'd7, 5'd5, 32'd9);
`ifdef DECODE_EXEC_FWD_EN
        chk("fwd_mem_priority", ex_result, 32'd7);
`else
        chk("fwd_disabled", ex_result, 32'd0);
`endif

        // beq x3,x3,-8 at pc 0x10
        run(32'hFE31_8CE3, 32'h10, 32'd3, 32'd3, 0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("beq_result", ex_result, 32'd1);
        chk("beq_target", ex_branch_addr, 32'h8);

        run(32'h1234_5337, 32'h14, 32'h5, 32'h6, 0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("lui_result", ex_result, 32'h1234_5000);
        run(32'h0000_1397, 32'h20, 32'h5, 32'h6, 0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("auipc_result", ex_result, 32'h1020);

        run(32'h4031_50B3, 32'h24, 32'h8000_0000, 32'd4, 0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("sra_result", ex_result, 32'hF800_0000);
        run(32'h0031_30B3, 32'h28, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("sltu_result", ex_result, 32'd1);
        run(32'h0031_20B3, 32'h2C, 32'd1, 32'hFFFF_FFFF, 0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("slt_result", ex_result, 32'd0);

        // sw x2,0(x1) squashed by flush, then by stall
        run(32'h0020_A023, 32'h30, 32'h100, 32'hAB, 1, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("flush_mw", 32'(ex_mem_write), 32'd0);
        chk("flush_rw", 32'(ex_reg_write), 32'd0);
        run(32'h0020_A023, 32'h34, 32'h100, 32'hAB, 0, 1, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        chk("stall_mw", 32'(ex_mem_write), 32'd0);

        // reset mid-stream dominates a valid instruction with flush asserted
        run(32'h0050_0293, 32'h38, 32'h0, 32'h0, 0, 0, 0, 5'd0, 32'h0, 5'd0, 32'h0);
        id_instr = 32'h0020_A023; id_pc = 32'h3C; reset = 1'b1; flush = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; flush = 1'b0;
        #1;
        chk("midrst_result", ex_result, 32'h0);
        chk("midrst_pc", ex_pc, 32'h0);
        chk("midrst_flags", 32'({ex_jal, ex_jalr, ex_branch, ex_mem_read, ex_mem_write, ex_reg_write}), 32'h0);

        // random instruction stream
        for (int n = 0; n < 300; n++) begin
            ins = $urandom;
            ins[6:0] = ops[$urandom_range(0, 9)];
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            if (ins[6:0] == 7'h63 && ins[14:13] == 2'b01) ins[14] = 1'b1;
            run(ins, $urandom, $urandom, $urandom, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
                1'($urandom), 5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
